// File: rtl/load_value_predictor_pkg.sv
// Shared types and constants for the last-value load predictor.
package load_value_predictor_pkg;

    localparam int LVP_ENTRIES     = 64;
    localparam int LVP_ADDR_WIDTH  = 32;
    localparam int LVP_DATA_WIDTH  = 32;
    localparam int LVP_CONF_BITS   = 2;
    localparam int LVP_CONF_THRESH = 2;
    localparam int LVP_IDX_W       = $clog2(LVP_ENTRIES);
    localparam int LVP_TAG_W       = LVP_ADDR_WIDTH - LVP_IDX_W - 2;

    // Speculation lifecycle: nothing outstanding, waiting for the real value, or restoring.
    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        WAIT    = 2'd1,
        RECOVER = 2'd2
    } lvp_state_t;

    // Layout of one direct-mapped table entry at the default geometry.
    typedef struct packed {
        logic                      valid;
        logic [LVP_TAG_W-1:0]      tag;
        logic [LVP_DATA_WIDTH-1:0] value;
        logic [LVP_CONF_BITS-1:0]  conf;
    } lvp_entry_t;

endpackage

// File: rtl/load_value_predictor_table.sv
// Direct-mapped last-value table: async valid-clear, combinational lookup port,
// and one synchronous training port that does its own read-modify-write.
module lvp_table
    import load_value_predictor_pkg::*;
#(
    parameter int ENTRIES    = LVP_ENTRIES,
    parameter int ADDR_WIDTH = LVP_ADDR_WIDTH,
    parameter int DATA_WIDTH = LVP_DATA_WIDTH,
    parameter int CONF_BITS  = LVP_CONF_BITS
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [ADDR_WIDTH-1:0] rd_pc,
    output logic                  rd_hit,
    output logic [DATA_WIDTH-1:0] rd_value,
    output logic [CONF_BITS-1:0]  rd_conf,
    input  logic                  train_valid,
    input  logic [ADDR_WIDTH-1:0] train_pc,
    input  logic [DATA_WIDTH-1:0] train_data
);

    localparam int IDX_W = $clog2(ENTRIES);
    localparam int TAG_W = ADDR_WIDTH - IDX_W - 2;
    localparam logic [CONF_BITS-1:0] CONF_MAX = {CONF_BITS{1'b1}};

    logic [ENTRIES-1:0]    valid_q;
    logic [ENTRIES-1:0]    valid_d;
    logic [TAG_W-1:0]      tag_q   [ENTRIES];
    logic [DATA_WIDTH-1:0] value_q [ENTRIES];
    logic [CONF_BITS-1:0]  conf_q  [ENTRIES];

    logic [IDX_W-1:0]      rd_idx;
    logic [TAG_W-1:0]      rd_tag;
    logic [IDX_W-1:0]      wr_idx;
    logic [TAG_W-1:0]      wr_tag;
    logic                  wr_hit;
    logic [TAG_W-1:0]      tag_d;
    logic [DATA_WIDTH-1:0] value_d;
    logic [CONF_BITS-1:0]  conf_d;
    logic                  unused_pc_bits;

    assign rd_idx = rd_pc[IDX_W+1:2];
    assign rd_tag = rd_pc[ADDR_WIDTH-1:IDX_W+2];
    assign wr_idx = train_pc[IDX_W+1:2];
    assign wr_tag = train_pc[ADDR_WIDTH-1:IDX_W+2];

    // Word-aligned PCs: the byte-offset bits carry no information here.
    assign unused_pc_bits = ^{rd_pc[1:0], train_pc[1:0]};

    // Lookup port sees the current (pre-training) contents.
    always_comb begin
        rd_hit   = valid_q[rd_idx] && (tag_q[rd_idx] == rd_tag);
        rd_value = value_q[rd_idx];
        rd_conf  = conf_q[rd_idx];
    end

    // Training: matching value bumps confidence, anything else (re)writes value with conf 0.
    always_comb begin
        wr_hit  = valid_q[wr_idx] && (tag_q[wr_idx] == wr_tag);
        valid_d = valid_q;
        tag_d   = wr_tag;
        value_d = train_data;
        conf_d  = '0;
        if (train_valid) begin
            valid_d[wr_idx] = 1'b1;
            if (wr_hit && (value_q[wr_idx] == train_data)) begin
                conf_d = (conf_q[wr_idx] == CONF_MAX) ? CONF_MAX : conf_q[wr_idx] + 1'b1;
            end
        end
    end

    // Valid bits are the only state that must be cleared on reset.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            valid_q <= '0;
        end else begin
            valid_q <= valid_d;
        end
    end

    // Tag, value and confidence are meaningless while invalid, so they carry no reset.
    always_ff @(posedge clk) begin
        if (train_valid) begin
            tag_q[wr_idx]   <= tag_d;
            value_q[wr_idx] <= value_d;
            conf_q[wr_idx]  <= conf_d;
        end
    end

endmodule

// File: rtl/load_value_predictor.sv
// Last-value load predictor: issues one speculative value at a time, holds a lock
// until it resolves, and drives the snapshot-recovery handshake on a misprediction.
module load_value_predictor
    import load_value_predictor_pkg::*;
#(
    parameter int ENTRIES     = LVP_ENTRIES,
    parameter int ADDR_WIDTH  = LVP_ADDR_WIDTH,
    parameter int DATA_WIDTH  = LVP_DATA_WIDTH,
    parameter int CONF_BITS   = LVP_CONF_BITS,
    parameter int CONF_THRESH = LVP_CONF_THRESH
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  lookup_valid,
    input  logic [ADDR_WIDTH-1:0] lookup_pc,
    output logic                  pred_valid,
    output logic [DATA_WIDTH-1:0] pred_data,
    output logic                  lock,
    input  logic                  resolve_valid,
    input  logic [ADDR_WIDTH-1:0] resolve_pc,
    input  logic [DATA_WIDTH-1:0] resolve_data,
    input  logic                  flush,
    output logic                  recover,
    input  logic                  recovery_done,
    output logic                  recovery_done_ack
);

    lvp_state_t            state_q;
    lvp_state_t            state_d;
    logic                  pred_valid_q;
    logic                  pred_valid_d;
    logic [DATA_WIDTH-1:0] pred_data_q;
    logic [DATA_WIDTH-1:0] pred_data_d;
    logic [DATA_WIDTH-1:0] held_q;
    logic [DATA_WIDTH-1:0] held_d;
    logic                  ack_q;
    logic                  ack_d;

    logic                  rd_hit;
    logic [DATA_WIDTH-1:0] rd_value;
    logic [CONF_BITS-1:0]  rd_conf;
    logic                  issue;

    lvp_table #(
        .ENTRIES    (ENTRIES),
        .ADDR_WIDTH (ADDR_WIDTH),
        .DATA_WIDTH (DATA_WIDTH),
        .CONF_BITS  (CONF_BITS)
    ) u_table (
        .clk         (clk),
        .rst_n       (rst_n),
        .rd_pc       (lookup_pc),
        .rd_hit      (rd_hit),
        .rd_value    (rd_value),
        .rd_conf     (rd_conf),
        .train_valid (resolve_valid),
        .train_pc    (resolve_pc),
        .train_data  (resolve_data)
    );

    assign issue = (state_q == IDLE) && lookup_valid && rd_hit &&
                   (rd_conf >= CONF_BITS'(CONF_THRESH));

    assign pred_valid        = pred_valid_q;
    assign pred_data         = pred_data_q;
    assign lock              = (state_q != IDLE);
    assign recover           = (state_q == RECOVER);
    assign recovery_done_ack = ack_q;

    // Next state, one-shot prediction and recovery acknowledge.
    always_comb begin
        state_d      = state_q;
        pred_valid_d = 1'b0;
        pred_data_d  = '0;
        held_d       = held_q;
        ack_d        = 1'b0;
        case (state_q)
            IDLE: begin
                if (issue) begin
                    state_d      = WAIT;
                    pred_valid_d = 1'b1;
                    pred_data_d  = rd_value;
                    held_d       = rd_value;
                end
            end
            WAIT: begin
                if (resolve_valid) begin
                    state_d = (resolve_data == held_q) ? IDLE : RECOVER;
                end else if (flush) begin
                    state_d = IDLE;
                end
            end
            RECOVER: begin
                if (recovery_done) begin
                    state_d = IDLE;
                    ack_d   = 1'b1;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // Control and output registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= IDLE;
            pred_valid_q <= 1'b0;
            pred_data_q  <= '0;
            held_q       <= '0;
            ack_q        <= 1'b0;
        end else begin
            state_q      <= state_d;
            pred_valid_q <= pred_valid_d;
            pred_data_q  <= pred_data_d;
            held_q       <= held_d;
            ack_q        <= ack_d;
        end
    end

endmodule

// File: tb/tb_load_value_predictor.sv
// Directed bench for load_value_predictor with a behavioural reference model.
module tb_load_value_predictor;

    localparam int NENT     = 64;
    localparam int CONF_MAX = 3;
    localparam int THRESH   = 2;

    logic        clk;
    logic        rst_n;
    logic        lookup_valid;
    logic [31:0] lookup_pc;
    logic        pred_valid;
    logic [31:0] pred_data;
    logic        lock;
    logic        resolve_valid;
    logic [31:0] resolve_pc;
    logic [31:0] resolve_data;
    logic        flush;
    logic        recover;
    logic        recovery_done;
    logic        recovery_done_ack;

    int tests = 0;
    int fails = 0;

    load_value_predictor dut (
        .clk               (clk),
        .rst_n             (rst_n),
        .lookup_valid      (lookup_valid),
        .lookup_pc         (lookup_pc),
        .pred_valid        (pred_valid),
        .pred_data         (pred_data),
        .lock              (lock),
        .resolve_valid     (resolve_valid),
        .resolve_pc        (resolve_pc),
        .resolve_data      (resolve_data),
        .flush             (flush),
        .recover           (recover),
        .recovery_done     (recovery_done),
        .recovery_done_ack (recovery_done_ack)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference model: table keyed by word index, tag is the PC above the index bits.
    bit          m_valid [NENT];
    logic [31:0] m_tag   [NENT];
    logic [31:0] m_value [NENT];
    int          m_conf  [NENT];
    bit          spec_open;
    bit          recovering;
    logic [31:0] held;
    bit          e_pv;
    logic [31:0] e_pd;
    bit          e_ack;
    int          li;
    int          ri;
    bit          lhit;
    bit          rhit;
    bit          issue;

    // Model advances on every clock edge and clears at once on reset.
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < NENT; i++) m_valid[i] = 1'b0;
            spec_open  = 1'b0;
            recovering = 1'b0;
            held       = '0;
            e_pv       = 1'b0;
            e_pd       = '0;
            e_ack      = 1'b0;
        end else begin
            li    = int'((lookup_pc / 4) % NENT);
            lhit  = m_valid[li] && (m_tag[li] == lookup_pc / (NENT * 4));
            issue = !spec_open && !recovering && lookup_valid && lhit && (m_conf[li] >= THRESH);
            e_pv  = issue;
            e_pd  = issue ? m_value[li] : 32'h0;
            e_ack = 1'b0;
            if (spec_open) begin
                if (resolve_valid) begin
                    spec_open  = 1'b0;
                    recovering = (resolve_data != held);
                end else if (flush) begin
                    spec_open = 1'b0;
                end
            end else if (recovering) begin
                if (recovery_done) begin
                    recovering = 1'b0;
                    e_ack      = 1'b1;
                end
            end else if (issue) begin
                spec_open = 1'b1;
                held      = m_value[li];
            end
            if (resolve_valid) begin
                ri   = int'((resolve_pc / 4) % NENT);
                rhit = m_valid[ri] && (m_tag[ri] == resolve_pc / (NENT * 4));
                if (rhit && m_value[ri] == resolve_data) begin
                    if (m_conf[ri] < CONF_MAX) m_conf[ri] = m_conf[ri] + 1;
                end else begin
                    m_valid[ri] = 1'b1;
                    m_tag[ri]   = resolve_pc / (NENT * 4);
                    m_value[ri] = resolve_data;
                    m_conf[ri]  = 0;
                end
            end
        end
    end

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        tests++;
        if (actual !== expected) begin
            fails++;
            $display("[TB] FAIL %s: got 0x%08h expected 0x%08h at %0t", name, actual, expected, $time);
        end
    endtask

    // Every cycle, compare the DUT against the model shortly after the edge.
    always begin
        @(posedge clk);
        #1;
        checkOutput("pred_valid", 32'(pred_valid), 32'(e_pv));
        checkOutput("lock", 32'(lock), 32'(spec_open || recovering));
        checkOutput("recover", 32'(recover), 32'(recovering));
        checkOutput("ack", 32'(recovery_done_ack), 32'(e_ack));
        if (e_pv) checkOutput("pred_data", pred_data, e_pd);
    end

    task automatic applyStimulus(input bit lv, input logic [31:0] lpc, input bit rv,
                                 input logic [31:0] rpc, input logic [31:0] rdata,
                                 input bit fl, input bit rdone);
        @(negedge clk);
        lookup_valid  = lv;
        lookup_pc     = lpc;
        resolve_valid = rv;
        resolve_pc    = rpc;
        resolve_data  = rdata;
        flush         = fl;
        recovery_done = rdone;
    endtask

    // Drive one cycle and return just after the edge that consumed it.
    task automatic cycle(input bit lv, input logic [31:0] lpc, input bit rv,
                         input logic [31:0] rpc, input logic [31:0] rdata,
                         input bit fl, input bit rdone);
        applyStimulus(lv, lpc, rv, rpc, rdata, fl, rdone);
        @(posedge clk);
        #2;
    endtask

    task automatic idle();
        cycle(0, 0, 0, 0, 0, 0, 0);
    endtask

    task automatic lookupCycle(input logic [31:0] pc);
        cycle(1, pc, 0, 0, 0, 0, 0);
    endtask

    task automatic resolveCycle(input logic [31:0] pc, input logic [31:0] data);
        cycle(0, 0, 1, pc, data, 0, 0);
    endtask

    task automatic checkAllZero(input string tag);
        checkOutput({tag, "_pv"}, 32'(pred_valid), 0);
        checkOutput({tag, "_pd"}, pred_data, 0);
        checkOutput({tag, "_lock"}, 32'(lock), 0);
        checkOutput({tag, "_rec"}, 32'(recover), 0);
        checkOutput({tag, "_ack"}, 32'(recovery_done_ack), 0);
    endtask

    initial begin
        rst_n = 1'b0;
        lookup_valid = 0; lookup_pc = 0; resolve_valid = 0; resolve_pc = 0;
        resolve_data = 0; flush = 0; recovery_done = 0;
        repeat (3) @(posedge clk);
        #2;
        checkAllZero("reset");
        @(negedge clk);
        rst_n = 1'b1;

        // Empty table never predicts.
        lookupCycle(32'h100);
        checkOutput("cold_pv", 32'(pred_valid), 0);
        checkOutput("cold_lock", 32'(lock), 0);

        // Three equal resolves take conf to 2, enough to predict.
        repeat (3) resolveCycle(32'h100, 32'hDEADBEEF);
        lookupCycle(32'h100);
        checkOutput("pred_pv", 32'(pred_valid), 1);
        checkOutput("pred_pd", pred_data, 32'hDEADBEEF);
        checkOutput("pred_lock", 32'(lock), 1);
        idle();
        checkOutput("pred_one_shot", 32'(pred_valid), 0);
        checkOutput("wait_lock", 32'(lock), 1);

        // Correct resolve releases the lock; conf saturates to 3 and still predicts.
        resolveCycle(32'h100, 32'hDEADBEEF);
        checkOutput("hit_unlock", 32'(lock), 0);
        checkOutput("hit_norec", 32'(recover), 0);
        lookupCycle(32'h100);
        checkOutput("repred_pv", 32'(pred_valid), 1);

        // Mispredict: recover held until recovery_done, then one-cycle ack.
        resolveCycle(32'h100, 32'h12345678);
        checkOutput("miss_rec", 32'(recover), 1);
        repeat (5) idle();
        checkOutput("rec_held", 32'(recover), 1);
        cycle(0, 0, 0, 0, 0, 0, 1);
        checkOutput("done_ack", 32'(recovery_done_ack), 1);
        checkOutput("done_rec", 32'(recover), 0);
        checkOutput("done_lock", 32'(lock), 0);
        idle();
        checkOutput("ack_pulse", 32'(recovery_done_ack), 0);
        lookupCycle(32'h100);
        checkOutput("retrained_pv", 32'(pred_valid), 0);

        // Aliasing PC replaces the entry.
        repeat (2) resolveCycle(32'h100, 32'h12345678);
        resolveCycle(32'h200, 32'hCAFEF00D);
        lookupCycle(32'h100);
        checkOutput("alias_pv", 32'(pred_valid), 0);
        lookupCycle(32'h200);
        checkOutput("alias_new_pv", 32'(pred_valid), 0);

        // Flush in WAIT drops lock without recovery; lookups in WAIT are ignored.
        repeat (2) resolveCycle(32'h200, 32'hCAFEF00D);
        lookupCycle(32'h200);
        checkOutput("f_pd", pred_data, 32'hCAFEF00D);
        cycle(1, 32'h200, 0, 0, 0, 1, 0);
        checkOutput("flush_lock", 32'(lock), 0);
        checkOutput("flush_pv", 32'(pred_valid), 0);
        checkOutput("flush_rec", 32'(recover), 0);

        // Flush together with a wrong resolve: resolve wins; flush ignored in RECOVER.
        lookupCycle(32'h200);
        cycle(0, 0, 1, 32'h200, 32'h1, 1, 0);
        checkOutput("prio_rec", 32'(recover), 1);
        cycle(0, 0, 0, 0, 0, 1, 0);
        checkOutput("rec_flush_ign", 32'(recover), 1);
        cycle(0, 0, 0, 0, 0, 0, 1);
        checkOutput("prio_ack", 32'(recovery_done_ack), 1);

        // Same-cycle lookup and resolve: lookup sees the old value.
        repeat (2) resolveCycle(32'h200, 32'h1);
        cycle(1, 32'h200, 1, 32'h200, 32'h5, 0, 0);
        checkOutput("rbw_pv", 32'(pred_valid), 1);
        checkOutput("rbw_pd", pred_data, 32'h1);
        resolveCycle(32'h200, 32'h1);
        checkOutput("rbw_unlock", 32'(lock), 0);
        checkOutput("rbw_norec", 32'(recover), 0);

        // Async reset while in WAIT.
        repeat (2) resolveCycle(32'h200, 32'h1);
        lookupCycle(32'h200);
        checkOutput("pre_rst_pv", 32'(pred_valid), 1);
        rst_n = 1'b0;
        #1;
        checkAllZero("rst_wait");
        @(negedge clk);
        rst_n = 1'b1;
        lookupCycle(32'h200);
        checkOutput("post_rst_pv", 32'(pred_valid), 0);

        // Async reset while in RECOVER.
        repeat (3) resolveCycle(32'h200, 32'h7);
        lookupCycle(32'h200);
        resolveCycle(32'h200, 32'h8);
        checkOutput("pre_rst2_rec", 32'(recover), 1);
        rst_n = 1'b0;
        #1;
        checkAllZero("rst_rec");
        @(negedge clk);
        rst_n = 1'b1;
        lookupCycle(32'h200);
        checkOutput("post_rst2_pv", 32'(pred_valid), 0);
        lookupCycle(32'h100);
        checkOutput("post_rst2_pv100", 32'(pred_valid), 0);
        idle();

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
